// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : operand_loader
// Purpose  : Debounces enter/swap/clear buttons and sequences single-cycle
//            load_a / load_b / swap strobes with the captured switch word.
// Revision : 1.0
// ============================================================================
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WIDTH           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  input  logic             btn_swap,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] data_out,
  output logic             load_a,
  output logic             load_b,
  output logic             swap,
  output logic [1:0]       state
);

  localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] WAIT_A = 2'b00;
  localparam logic [1:0] WAIT_B = 2'b01;
  localparam logic [1:0] READY  = 2'b10;

  localparam int BTN_ENTER = 0;
  localparam int BTN_SWAP  = 1;
  localparam int BTN_CLEAR = 2;

  logic [2:0] btn_raw;
  logic [2:0] btn_event;

  assign btn_raw = {btn_clear, btn_swap, btn_enter};

  generate
    for (genvar g = 0; g < 3; g++) begin : g_btn
      logic             sync1_q, sync1_d;
      logic             sync2_q, sync2_d;
      logic             level_q, level_d;
      logic             level_prev_q, level_prev_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] cnt_inc;

      // Counter only runs while the synchronized input disagrees with the
      // accepted level; it clears on agreement and on reaching the limit.
      always_comb begin
        sync1_d      = btn_raw[g];
        sync2_d      = sync1_q;
        level_prev_d = level_q;
        level_d      = level_q;
        cnt_d        = '0;
        cnt_inc      = cnt_q + CNT_ONE;
        if (sync2_q != level_q) begin
          if (cnt_inc == CNT_LIMIT) begin
            level_d = ~level_q;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_q      <= 1'b0;
          sync2_q      <= 1'b0;
          level_q      <= 1'b0;
          level_prev_q <= 1'b0;
          cnt_q        <= '0;
        end else begin
          sync1_q      <= sync1_d;
          sync2_q      <= sync2_d;
          level_q      <= level_d;
          level_prev_q <= level_prev_d;
          cnt_q        <= cnt_d;
        end
      end

      assign btn_event[g] = level_q & ~level_prev_q;
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load_a_q, load_a_d;
  logic             load_b_q, load_b_d;
  logic             swap_q, swap_d;

  // Priority clear > enter > swap; losing events are simply dropped.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    load_a_d = 1'b0;
    load_b_d = 1'b0;
    swap_d   = 1'b0;
    if (btn_event[BTN_CLEAR]) begin
      state_d = WAIT_A;
    end else if (btn_event[BTN_ENTER]) begin
      data_d = sw;
      case (state_q)
        WAIT_B: begin
          load_b_d = 1'b1;
          state_d  = READY;
        end
        default: begin
          load_a_d = 1'b1;
          state_d  = WAIT_B;
        end
      endcase
    end else if (btn_event[BTN_SWAP] && (state_q == READY)) begin
      swap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_A;
      data_q   <= '0;
      load_a_q <= 1'b0;
      load_b_q <= 1'b0;
      swap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      load_a_q <= load_a_d;
      load_b_q <= load_b_d;
      swap_q   <= swap_d;
    end
  end

  assign data_out = data_q;
  assign load_a   = load_a_q;
  assign load_b   = load_b_q;
  assign swap     = swap_q;
  assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_loader
// Purpose  : Directed and randomized checks of operand_loader against a
//            window-based behavioural model of debounce and sequencing.
// Revision : 1.0
// ============================================================================
module tb_operand_loader;

  localparam int          D    = 4;
  localparam int          W    = 8;
  localparam logic [31:0] MASK = (32'd1 << D) - 32'd1;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw;
  logic         btn_enter, btn_swap, btn_clear;
  logic [W-1:0] data_out;
  logic         load_a, load_b, swap;
  logic [1:0]   state;

  operand_loader #(.DEBOUNCE_CYCLES(D), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .btn_enter(btn_enter), .btn_swap(btn_swap), .btn_clear(btn_clear),
    .data_out(data_out), .load_a(load_a), .load_b(load_b),
    .swap(swap), .state(state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: a button's accepted level flips once the last D synchronized
  // samples all disagree with it; a press is a rising accepted level.
  bit          m_s1[3], m_s2[3], m_acc[3], m_prev[3];
  logic [31:0] m_hist[3];
  logic [W-1:0] m_data;
  bit          m_la, m_lb, m_sp;
  int          m_state;

  int edge_no, first_la, la_cnt, lb_cnt, sp_cnt;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_acc[b] = 0; m_prev[b] = 0; m_hist[b] = '0;
    end
    m_data = '0; m_la = 0; m_lb = 0; m_sp = 0; m_state = 0;
  endtask

  task automatic model_edge();
    bit   ev[3];
    logic [2:0] raw;
    raw = {btn_clear, btn_swap, btn_enter};
    for (int b = 0; b < 3; b++) ev[b] = m_acc[b] && !m_prev[b];
    m_la = 0; m_lb = 0; m_sp = 0;
    if (ev[2]) begin
      m_state = 0;
    end else if (ev[0]) begin
      m_data = sw;
      if (m_state == 1) begin m_lb = 1; m_state = 2; end
      else begin m_la = 1; m_state = 1; end
    end else if (ev[1] && m_state == 2) begin
      m_sp = 1;
    end
    for (int b = 0; b < 3; b++) begin
      m_prev[b] = m_acc[b];
      m_hist[b] = {m_hist[b][30:0], m_s2[b]};
      if (m_acc[b] ? ((m_hist[b] & MASK) == 32'd0) : ((m_hist[b] & MASK) == MASK))
        m_acc[b] = !m_acc[b];
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".data_out"}, 32'(data_out), 32'(m_data));
    check({tag, ".load_a"},   32'(load_a),   32'(m_la));
    check({tag, ".load_b"},   32'(load_b),   32'(m_lb));
    check({tag, ".swap"},     32'(swap),     32'(m_sp));
    check({tag, ".state"},    32'(state),    32'(m_state));
  endtask

  task automatic clear_counts();
    edge_no = 0; first_la = 0; la_cnt = 0; lb_cnt = 0; sp_cnt = 0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all("cyc");
      edge_no++;
      if (load_a) begin la_cnt++; if (first_la == 0) first_la = edge_no; end
      if (load_b) lb_cnt++;
      if (swap)   sp_cnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    check("rst.data_out_zero", 32'(data_out), 32'h0);
    check("rst.state_zero",    32'(state),    32'h0);
    check("rst.strobes_zero",  32'({load_a, load_b, swap}), 32'h0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    sw = '0; btn_enter = 0; btn_swap = 0; btn_clear = 0; reset = 0;
    model_reset();
    do_reset();

    // First operand: load_a on the 7th edge after the press.
    clear_counts();
    sw = 8'h3C; btn_enter = 1; run(10);
    btn_enter = 0; run(8);
    check("enter1.first_la", 32'(first_la), 32'd7);
    check("enter1.la_cnt",   32'(la_cnt),   32'd1);
    check("enter1.data",     32'(data_out), 32'h3C);
    check("enter1.state",    32'(state),    32'd1);

    clear_counts();
    sw = 8'hA5; btn_enter = 1; run(10);
    btn_enter = 0; run(8);
    check("enter2.lb_cnt", 32'(lb_cnt),   32'd1);
    check("enter2.la_cnt", 32'(la_cnt),   32'd0);
    check("enter2.data",   32'(data_out), 32'hA5);
    check("enter2.state",  32'(state),    32'd2);

    clear_counts();
    sw = 8'h0F; btn_swap = 1; run(8);
    btn_swap = 0; run(8);
    check("swap_ready.sp_cnt", 32'(sp_cnt),   32'd1);
    check("swap_ready.data",   32'(data_out), 32'hA5);
    check("swap_ready.state",  32'(state),    32'd2);

    btn_clear = 1; run(8); btn_clear = 0; run(8);
    check("clear.state", 32'(state),    32'd0);
    check("clear.data",  32'(data_out), 32'hA5);
    clear_counts();
    btn_swap = 1; run(8); btn_swap = 0; run(8);
    check("swap_wait_a.sp_cnt", 32'(sp_cnt), 32'd0);
    check("swap_wait_a.state",  32'(state),  32'd0);

    // Glitches of 1, 2, 3 cycles never reach the debounce limit.
    clear_counts();
    btn_enter = 1; run(1); btn_enter = 0; run(1);
    btn_enter = 1; run(2); btn_enter = 0; run(1);
    btn_enter = 1; run(3); btn_enter = 0; run(8);
    check("glitch.strobes", 32'(la_cnt + lb_cnt + sp_cnt), 32'd0);
    check("glitch.state",   32'(state), 32'd0);

    // Coincident enter+clear in WAIT_B: clear wins, data holds.
    sw = 8'h11; btn_enter = 1; run(10); btn_enter = 0; run(8);
    check("pre_coinc.state", 32'(state), 32'd1);
    clear_counts();
    sw = 8'h77; btn_enter = 1; btn_clear = 1; run(10);
    btn_enter = 0; btn_clear = 0; run(8);
    check("coinc.strobes", 32'(la_cnt + lb_cnt + sp_cnt), 32'd0);
    check("coinc.state",   32'(state),    32'd0);
    check("coinc.data",    32'(data_out), 32'h11);

    // Reset mid-debounce; held button then takes a full latency.
    sw = 8'h5A; btn_enter = 1; run(3);
    do_reset();
    clear_counts();
    run(10);
    check("post_rst.first_la", 32'(first_la), 32'd7);
    check("post_rst.data",     32'(data_out), 32'h5A);
    btn_enter = 0; run(8);

    btn_clear = 1; run(8); btn_clear = 0; run(8);
    clear_counts();
    sw = 8'hC3; btn_enter = 1; run(50); btn_enter = 0; run(10);
    check("hold50.la_cnt", 32'(la_cnt), 32'd1);
    check("hold50.lb_cnt", 32'(lb_cnt), 32'd0);
    check("hold50.state",  32'(state),  32'd1);
    clear_counts();
    sw = 8'h96; btn_enter = 1; run(10); btn_enter = 0; run(8);
    check("second.lb_cnt", 32'(lb_cnt),   32'd1);
    check("second.data",   32'(data_out), 32'h96);
    check("second.state",  32'(state),    32'd2);

    // Random segments: buttons held for 1..8 cycles, occasional reset.
    for (int i = 0; i < 400; i++) begin
      sw        = W'($urandom);
      btn_enter = 1'($urandom_range(0, 1));
      btn_swap  = 1'($urandom_range(0, 1));
      btn_clear = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) do_reset();
      run(int'($urandom_range(1, 8)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
